// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation searcher:
// state encoding and the default search width.
package sar_pkg;

   // Default width of target, trial and result
   localparam int DEFAULT_WIDTH = 2;

   // FSM state encoding; 2'b11 is unused and recovers to IDLE
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] TEST = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation searcher. Recovers an unknown target one bit per
// clock, MSB first, from a comparator answer lt_in = (target < trial).
// The trial word is driven to the comparator; the corrected trial becomes
// the result after WIDTH test cycles.
import sar_pkg::*;

module sar_search #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             lt_in,
   output logic [WIDTH-1:0] trial,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   // Bit index needs at least one bit even when WIDTH is 1
   localparam int               IDXW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] TOP_BIT = WIDTH'(1) << (WIDTH - 1);

   logic [1:0]       state_reg;
   logic [WIDTH-1:0] trial_reg;
   logic [WIDTH-1:0] result_reg;
   logic [IDXW-1:0]  idx_reg;
   logic             busy_reg;
   logic             done_reg;

   logic [WIDTH-1:0] bit_mask;
   logic [WIDTH-1:0] next_mask;
   logic [WIDTH-1:0] corrected;

   // One-hot mask of the bit currently under test, decoded from idx_reg
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
         assign bit_mask[gi] = (idx_reg == IDXW'(gi));
      end
   endgenerate

   // Mask of the next bit to try; unused once idx_reg reaches zero
   assign next_mask = bit_mask >> 1;

   // Trial with the tested bit cleared when it overshoots the target
   assign corrected = trial_reg & ~(bit_mask & {WIDTH{lt_in}});

   // Search FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         trial_reg  <= '0;
         result_reg <= '0;
         idx_reg    <= IDX_TOP;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  state_reg <= TEST;
                  trial_reg <= TOP_BIT;
                  idx_reg   <= IDX_TOP;
                  busy_reg  <= 1'b1;
               end
            end
            TEST: begin
               if (idx_reg != '0) begin
                  trial_reg <= corrected | next_mask;
                  idx_reg   <= idx_reg - 1'b1;
               end else begin
                  trial_reg  <= corrected;
                  result_reg <= corrected;
                  state_reg  <= DONE;
                  busy_reg   <= 1'b0;
                  done_reg   <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
               idx_reg   <= IDX_TOP;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               idx_reg   <= IDX_TOP;
            end
         endcase
      end
   end

   assign trial  = trial_reg;
   assign result = result_reg;
   assign busy   = busy_reg;
   assign done   = done_reg;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: three instances (WIDTH 2, 4, 1), each closed around a
// behavioural less-than comparator. A cycle-level model predicts every output
// from the target alone; directed sequences pin that model with literals.
module tb_sar_search;

   logic       clk;
   logic       rst_n;
   logic       start2, start4, start1;
   logic [1:0] tgt2;
   logic [3:0] tgt4;
   logic [0:0] tgt1;
   logic       lt2, lt4, lt1;
   logic [1:0] trial2, result2;
   logic [3:0] trial4, result4;
   logic [0:0] trial1, result1;
   logic       busy2, busy4, busy1;
   logic       done2, done4, done1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Behavioural comparators cmp_lt: target on A/B, trial on C/D
   assign lt2 = (tgt2 < trial2);
   assign lt4 = (tgt4 < trial4);
   assign lt1 = (tgt1 < trial1);

   sar_search #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .lt_in(lt2),
      .trial(trial2), .busy(busy2), .done(done2), .result(result2)
   );
   sar_search #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .lt_in(lt4),
      .trial(trial4), .busy(busy4), .done(done4), .result(result4)
   );
   sar_search #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .lt_in(lt1),
      .trial(trial1), .busy(busy1), .done(done1), .result(result1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase -1: idle; 0..W-1: testing bit W-1-phase; W: done cycle
   localparam int W_OF [3] = '{2, 4, 1};
   int phase [3];
   int m_res [3];
   int m_tg  [3];
   int m_st  [3];
   int m_tr  [3];
   int m_rs  [3];
   int m_bz  [3];
   int m_dn  [3];
   int e_tr, e_rs, e_bz, e_dn;

   // Trial while testing bit W-1-k: target bits above it, that bit set, rest 0
   function automatic int exp_trial(input int w, input int t, input int k);
      int hi;
      hi = (t >> (w - k)) << (w - k);
      return hi | (1 << (w - 1 - k));
   endfunction

   // Advance the model on each edge; reset clears everything
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            phase[i] = -1;
            m_res[i] = 0;
         end
      end else begin
         m_st[0] = int'(start2); m_st[1] = int'(start4); m_st[2] = int'(start1);
         m_tg[0] = int'(tgt2);   m_tg[1] = int'(tgt4);   m_tg[2] = int'(tgt1);
         for (int i = 0; i < 3; i++) begin
            if (phase[i] < 0) begin
               if (m_st[i] != 0) phase[i] = 0;
            end else if (phase[i] < W_OF[i] - 1) begin
               phase[i] = phase[i] + 1;
            end else if (phase[i] == W_OF[i] - 1) begin
               phase[i] = W_OF[i];
               m_res[i] = m_tg[i];
            end else begin
               phase[i] = -1;
            end
         end
      end
   end

   // Compare every DUT output against the model on each falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         m_tg[0] = int'(tgt2);    m_tg[1] = int'(tgt4);    m_tg[2] = int'(tgt1);
         m_tr[0] = int'(trial2);  m_tr[1] = int'(trial4);  m_tr[2] = int'(trial1);
         m_rs[0] = int'(result2); m_rs[1] = int'(result4); m_rs[2] = int'(result1);
         m_bz[0] = int'(busy2);   m_bz[1] = int'(busy4);   m_bz[2] = int'(busy1);
         m_dn[0] = int'(done2);   m_dn[1] = int'(done4);   m_dn[2] = int'(done1);
         for (int i = 0; i < 3; i++) begin
            if (phase[i] < 0) begin
               e_tr = m_res[i]; e_rs = m_res[i]; e_bz = 0; e_dn = 0;
            end else if (phase[i] < W_OF[i]) begin
               e_tr = exp_trial(W_OF[i], m_tg[i], phase[i]);
               e_rs = m_res[i]; e_bz = 1; e_dn = 0;
            end else begin
               e_tr = m_res[i]; e_rs = m_res[i]; e_bz = 0; e_dn = 1;
            end
            chk($sformatf("model_trial_w%0d", W_OF[i]),  m_tr[i], e_tr);
            chk($sformatf("model_result_w%0d", W_OF[i]), m_rs[i], e_rs);
            chk($sformatf("model_busy_w%0d", W_OF[i]),   m_bz[i], e_bz);
            chk($sformatf("model_done_w%0d", W_OF[i]),   m_dn[i], e_dn);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic set_start(input int i, input logic v);
      case (i)
         0: start2 = v;
         1: start4 = v;
         default: start1 = v;
      endcase
   endtask

   // One-cycle start: raised after an edge, sampled at the next (E0)
   task automatic pulse(input int i);
      @(posedge clk); #2 set_start(i, 1'b1);
      @(posedge clk); #2 set_start(i, 1'b0);
   endtask

   task automatic hand2(input logic [1:0] tg, input logic [1:0] t0, input logic [1:0] t1,
                        input logic l0, input logic l1, input logic [1:0] r);
      int bc;
      tgt2 = tg;
      pulse(0);
      bc = 0;
      @(negedge clk); chk("w2_trial_e0", trial2, t0); chk("w2_lt_e0", lt2, l0); bc += int'(busy2);
      @(negedge clk); chk("w2_trial_e1", trial2, t1); chk("w2_lt_e1", lt2, l1); bc += int'(busy2);
      @(negedge clk); chk("w2_done", done2, 1); chk("w2_result", result2, r); bc += int'(busy2);
      @(negedge clk); chk("w2_done_gone", done2, 0); bc += int'(busy2);
      chk("w2_busy_cycles", bc, 2);
   endtask

   task automatic hand1(input logic tg);
      tgt1 = tg;
      pulse(2);
      @(negedge clk); chk("w1_trial", trial1, 1); chk("w1_busy", busy1, 1); chk("w1_done_early", done1, 0);
      @(negedge clk); chk("w1_done", done1, 1); chk("w1_result", result1, int'(tg));
      @(negedge clk); chk("w1_done_gone", done1, 0);
   endtask

   task automatic wait_done4(output int at);
      int found;
      found = 0;
      at = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done4) begin
            found = 1;
            at = cyc;
            break;
         end
      end
      chk("w4_done_seen", found, 1);
   endtask

   int at, prev, dcount;

   initial begin
      rst_n = 1'b0;
      start2 = 1'b0; start4 = 1'b0; start1 = 1'b0;
      tgt2 = '0; tgt4 = '0; tgt1 = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_trial4", trial4, 0);   chk("rst_result4", result4, 0);
      chk("rst_busy4", busy4, 0);     chk("rst_done4", done4, 0);

      // WIDTH=2 hand-computed sequences
      hand2(2'b10, 2'b10, 2'b11, 1'b0, 1'b1, 2'b10);
      hand2(2'b00, 2'b10, 2'b01, 1'b1, 1'b1, 2'b00);
      hand2(2'b11, 2'b10, 2'b11, 1'b0, 1'b0, 2'b11);

      // WIDTH=1
      hand1(1'b1);
      hand1(1'b0);

      // WIDTH=4 back-to-back sweep, restarting the cycle after each done
      prev = 0;
      for (int t = 0; t < 16; t++) begin
         tgt4 = 4'(t);
         pulse(1);
         wait_done4(at);
         chk("w4_sweep_result", result4, t);
         if (t > 0) chk("w4_done_spacing", at - prev, 6);
         prev = at;
      end

      // Asynchronous reset during the second TEST cycle
      tgt4 = 4'd9;
      pulse(1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_trial4", trial4, 0);   chk("arst_result4", result4, 0);
      chk("arst_busy4", busy4, 0);     chk("arst_done4", done4, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      dcount = 0;
      repeat (4) begin
         @(negedge clk);
         dcount += int'(done4);
      end
      chk("arst_no_done", dcount, 0);
      pulse(1);
      wait_done4(at);
      chk("arst_restart_result", result4, 9);

      // start held high: one search per IDLE entry, restart one edge after DONE
      tgt4 = 4'd6;
      @(posedge clk); #2 start4 = 1'b1;
      dcount = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         dcount += int'(done4);
      end
      start4 = 1'b0;
      repeat (2) begin
         @(negedge clk);
         dcount += int'(done4);
      end
      chk("held_start_done_count", dcount, 2);
      chk("held_start_result", result4, 6);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
